// File: rtl/rsa_result_collector.sv
// Captures one column-major X*Y result tile from the RSA array and replays it row-major
// over a valid/ready port; words arriving while a tile is draining are dropped and flagged.
module rsa_result_collector #(
  parameter int X          = 3,
  parameter int Y          = 3,
  parameter int OUT_LEN    = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  in_val,
  input  logic [OUT_LEN-1:0]    in_data,
  input  logic                  rd_rdy,
  output logic                  rd_val,
  output logic [OUT_LEN-1:0]    rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int N  = X * Y;
  localparam int RW = (X > 1) ? $clog2(X) : 1;
  localparam int CW = (Y > 1) ? $clog2(Y) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                  state;
  logic [RW-1:0]           row;
  logic [CW-1:0]           col;
  logic [OUT_LEN-1:0]      mem [0:N-1];
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [ADDR_WIDTH-1:0]   nxt_addr;
  logic                    wr_en;
  logic                    row_last;
  logic                    last_wr;
  logic                    last_rd;

  assign waddr    = ADDR_WIDTH'(row * Y + col);
  assign nxt_addr = rd_addr + 1'b1;
  assign wr_en    = in_val && (state != DRAIN);
  assign row_last = (row == RW'(X - 1));
  assign last_wr  = row_last && (col == CW'(Y - 1));
  assign last_rd  = (rd_addr == ADDR_WIDTH'(N - 1));
  assign busy     = (state != IDLE);

  // Tile storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= in_data;
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      rd_val  <= 1'b0;
      rd_data <= '0;
      rd_addr <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FILL: begin
          if (in_val) begin
            if (last_wr) begin
              row     <= '0;
              col     <= '0;
              state   <= DRAIN;
              rd_val  <= 1'b1;
              rd_addr <= '0;
              // A 1x1 tile writes index 0 on this very edge, so bypass the array.
              rd_data <= (waddr == '0) ? in_data : mem[0];
            end else begin
              state <= FILL;
              if (row_last) begin
                row <= '0;
                col <= col + 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (in_val) ovf <= 1'b1;
          if (rd_val && rd_rdy) begin
            if (last_rd) begin
              rd_val <= 1'b0;
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              rd_addr <= nxt_addr;
              rd_data <= mem[nxt_addr];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_result_collector.sv
// Bench for rsa_result_collector (X=Y=3): table-driven tile scenarios with a read-side scoreboard.
module tb_rsa_result_collector;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       in_val;
  logic [7:0] in_data;
  logic       rd_rdy;
  logic       rd_val;
  logic [7:0] rd_data;
  logic [3:0] rd_addr;
  logic       busy;
  logic       done;
  logic       ovf;

  always #5 clk = ~clk;

  rsa_result_collector #(.X(3), .Y(3), .OUT_LEN(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .sys_rst(sys_rst), .in_val(in_val), .in_data(in_data), .rd_rdy(rd_rdy),
    .rd_val(rd_val), .rd_data(rd_data), .rd_addr(rd_addr), .busy(busy), .done(done), .ovf(ovf)
  );

  typedef struct { int d; int a; } exp_t;
  typedef struct { int base; bit gaps; bit bp; bit inj; int exp_cycles; bit exp_ovf; } vec_t;

  exp_t       q[$];
  vec_t       tbl[4];
  int         tests = 0;
  int         fails = 0;
  int         done_cnt = 0;
  bit         bp = 1'b0;
  logic       hold = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] hold_d = '0;
  logic [3:0] hold_a = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Row-major read order of a column-major tile whose k-th arrival carries base+k.
  task automatic push_expected(input int base);
    for (int a = 0; a < 9; a++) begin
      exp_t e;
      e.d = base + (a % 3) * 3 + a / 3;
      e.a = a;
      q.push_back(e);
    end
  endtask

  task automatic send(input int base, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      in_val  = 1'b1;
      in_data = 8'(base + k);
      if (k == 8) check("no_early_val", rd_val, 0);
      @(posedge clk); #1;
      if (k == 8) begin
        check("first_val", rd_val, 1);
        check("first_addr", rd_addr, 0);
      end
      in_val = 1'b0;
      if (gaps && k < 8) begin
        check("gap_val", rd_val, 0);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 200);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", cycles);
    end
  endtask

  initial begin : ready_driver
    int ph;
    ph = 0;
    rd_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp) begin
        rd_rdy = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        rd_rdy = 1'b1;
        ph = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (hold) begin
        check("hold_val", rd_val, 1);
        check("hold_data", rd_data, hold_d);
        check("hold_addr", rd_addr, hold_a);
      end
      if (rd_val && rd_rdy) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got data %0d addr %0d, expected no transfer", rd_data, rd_addr);
        end else begin
          e = q.pop_front();
          check("rd_data", rd_data, e.d);
          check("rd_addr", rd_addr, e.a);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_width", prev_done, 0);
      end
      hold      = rd_val && !rd_rdy;
      hold_d    = rd_data;
      hold_a    = rd_addr;
      prev_done = done;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected bench to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc;
    int dc0;
    tbl[0] = '{base: 1, gaps: 1'b0, bp: 1'b0, inj: 1'b0, exp_cycles: 10, exp_ovf: 1'b0};
    tbl[1] = '{base: 1, gaps: 1'b0, bp: 1'b1, inj: 1'b0, exp_cycles: -1, exp_ovf: 1'b0};
    tbl[2] = '{base: 1, gaps: 1'b1, bp: 1'b0, inj: 1'b0, exp_cycles: 10, exp_ovf: 1'b0};
    tbl[3] = '{base: 1, gaps: 1'b0, bp: 1'b1, inj: 1'b1, exp_cycles: -1, exp_ovf: 1'b1};

    sys_rst = 1'b1;
    in_val  = 1'b0;
    in_data = '0;
    #12;
    check("rst_rd_val", rd_val, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    sys_rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      bp = tbl[i].bp;
      push_expected(tbl[i].base);
      dc0 = done_cnt;
      send(tbl[i].base, 9, tbl[i].gaps);
      check("busy_fill_drain", busy, 1);
      if (tbl[i].inj) begin
        in_val  = 1'b1;
        in_data = 8'hAA;
        @(posedge clk); #1;
        in_val = 1'b0;
        check("ovf_set", ovf, 1);
      end
      wait_done(cyc);
      check("busy_at_done", busy, 0);
      if (tbl[i].exp_cycles >= 0) check("drain_cycles", cyc, tbl[i].exp_cycles);
      @(negedge clk);
      check("done_pulses", done_cnt - dc0, 1);
      check("done_low", done, 0);
      check("ovf_after", ovf, tbl[i].exp_ovf);
      check("queue_empty", q.size(), 0);
      @(posedge clk); #1;
    end

    // Abort a half-filled tile with an asynchronous reset.
    bp = 1'b0;
    send(50, 5, 1'b0);
    check("busy_mid_fill", busy, 1);
    sys_rst = 1'b1;
    #1;
    check("mid_rst_rd_val", rd_val, 0);
    check("mid_rst_rd_data", rd_data, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ovf", ovf, 0);
    #2;
    sys_rst = 1'b0;
    @(posedge clk); #1;

    // Fresh tile after reset, then a second tile started in the done cycle.
    dc0 = done_cnt;
    push_expected(11);
    send(11, 9, 1'b0);
    wait_done(cyc);
    check("b2b_busy_at_done", busy, 0);
    push_expected(21);
    send(21, 9, 1'b0);
    wait_done(cyc);
    check("b2b_busy_end", busy, 0);
    @(negedge clk);
    check("b2b_done_pulses", done_cnt - dc0, 2);
    check("b2b_ovf", ovf, 0);
    check("b2b_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
